mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port 32-bit word memory behind a req/ready handshake with a fixed number of wait states.
// Faulting accesses (misaligned or beyond the array) complete with err and touch nothing.
module mem_responder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] WaitCnt = 4'(WAIT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [2**ADDR_W];

  logic        in_idle;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        mem_wr;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (|a[31:ADDR_W+2]);
  endfunction

  assign in_idle = (state_q == StIdle);

  // With WAIT=0 the write lands on the same edge that captures the request,
  // so the write port must see the live inputs while idle.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (in_idle) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = WaitCnt;
          state_d = (WAIT == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign mem_wr = (state_d == StDone) && (state_q != StDone) && acc_we &&
                  !is_fault(acc_addr) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[acc_addr[ADDR_W+1:2]] <= acc_wdata;
  end

  always_comb begin
    ready = (state_q == StDone);
    err   = ready && is_fault(addr_q);
    rdata = 32'd0;
    if (ready && !we_q && !err) rdata = mem[addr_q[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench for mem_responder: one instance with WAIT=2, one with WAIT=0.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req2, req0, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata2, rdata0;
  logic        ready2, ready0, err2, err0;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
    logic        after;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(6), .WAIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata2), .ready(ready2), .err(err2)
  );

  mem_responder #(.ADDR_W(6), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .ready(ready0), .err(err0)
  );

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input int lat);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.lat   = 8'(lat);
    e.after = 1'b0;
    return e;
  endfunction

  // Called just after a rising edge; lat counts edges from the sampling edge (=1) to ready.
  task automatic run_access(input bit use0, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input bit toggle, output exp_t got);
    got   = '0;
    we    = w;
    addr  = a;
    wdata = d;
    if (use0) req0 = 1'b1;
    else      req2 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      req0 = 1'b0;
      req2 = 1'b0;
      if (use0 ? ready0 : ready2) begin
        got.lat   = 8'(i);
        got.rdata = use0 ? rdata0 : rdata2;
        got.err   = use0 ? err0 : err2;
        break;
      end
      if (toggle) begin
        req2  = 1'($urandom);
        we    = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    req0 = 1'b0;
    req2 = 1'b0;
    @(posedge clk); #1;
    got.after = use0 ? ready0 : ready2;
  endtask

  task automatic test_reset();
    logic [65:0] obs;
    rst = 1'b0; req2 = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #1 rst = 1'b1;
    #1;
    obs = {ready2, err2, rdata2, ready0, err0, rdata0};
    vectors++;
    if (obs !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", obs);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    exp_t got, e;
    sb.push_back(mk(32'h0, 1'b0, 3));
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL wr_0x10 got %h want %h", got, e); end
    sb.push_back(mk(32'hDEADBEEF, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_0x10 got %h want %h", got, e); end
  endtask

  task automatic test_misaligned();
    exp_t got, e;
    sb.push_back(mk(32'h0, 1'b1, 3));
    run_access(1'b0, 1'b0, 32'h13, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_mis_0x13 got %h want %h", got, e); end
    sb.push_back(mk(32'h0, 1'b1, 3));
    run_access(1'b0, 1'b1, 32'h12, 32'h0BADF00D, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL wr_mis_0x12 got %h want %h", got, e); end
    sb.push_back(mk(32'hDEADBEEF, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_after_mis got %h want %h", got, e); end
  endtask

  task automatic test_out_of_range();
    exp_t got, e;
    logic [31:0] a [5]  = '{32'h0, 32'h100, 32'h80000000, 32'h0, 32'hFC};
    logic        w [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] d [5]  = '{32'h11111111, 32'hBAD0BAD0, 32'h0, 32'h0, 32'hFEEDFACE};
    logic [31:0] rd [5] = '{32'h0, 32'h0, 32'h0, 32'h11111111, 32'h0};
    logic        er [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(rd[i], er[i], 3));
      run_access(1'b0, w[i], a[i], d[i], 1'b0, got);
      e = sb.pop_front(); vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL oor_step%0d addr %h got %h want %h", i, a[i], got, e);
      end
    end
    sb.push_back(mk(32'hFEEDFACE, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'hFC, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_top_word got %h want %h", got, e); end
  endtask

  task automatic test_reset_abort();
    exp_t got, e;
    int pulses = 0;
    logic [33:0] obs;
    sb.push_back(mk(32'h0, 1'b0, 3));
    run_access(1'b0, 1'b1, 32'h20, 32'h0000AAAA, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL wr_0x20 got %h want %h", got, e); end
    we = 1'b1; addr = 32'h20; wdata = 32'h99999999; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    obs = {ready2, err2, rdata2};
    vectors++;
    if (obs !== 34'd0) begin miscompares++; $display("FAIL rst_mid_outputs got %h want 0", obs); end
    #1 rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready2) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("FAIL rst_no_ready got %0d want 0", pulses); end
    sb.push_back(mk(32'h0000AAAA, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'h20, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_after_abort got %h want %h", got, e); end
  endtask

  task automatic test_wait0();
    exp_t got, e;
    logic [32:0] obs, want;
    sb.push_back(mk(32'h0, 1'b0, 1));
    run_access(1'b1, 1'b1, 32'h8, 32'hCAFE0008, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL w0_wr got %h want %h", got, e); end
    sb.push_back(mk(32'hCAFE0008, 1'b0, 1));
    run_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL w0_rd got %h want %h", got, e); end
    we = 1'b0; addr = 32'h8; req0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      want = (i % 2 == 1) ? {1'b1, 32'hCAFE0008} : 33'd0;
      obs  = {ready0, rdata0};
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL w0_held_req cycle %0d got %h want %h", i, obs, want);
      end
    end
    req0 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_in_wait();
    exp_t got, e;
    sb.push_back(mk(32'h0, 1'b0, 3));
    run_access(1'b0, 1'b1, 32'h34, 32'h55555555, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL wr_0x34 got %h want %h", got, e); end
    for (int k = 0; k < 3; k++) begin
      sb.push_back(mk(32'h0, 1'b0, 3));
      run_access(1'b0, 1'b1, 32'h30, 32'h12345678 + k, 1'b1, got);
      e = sb.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL wr_toggled%0d got %h want %h", k, got, e); end
    end
    sb.push_back(mk(32'h1234567A, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'h30, 32'h0, 1'b1, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_0x30 got %h want %h", got, e); end
    sb.push_back(mk(32'h55555555, 1'b0, 3));
    run_access(1'b0, 1'b0, 32'h34, 32'h0, 1'b0, got);
    e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rd_0x34 got %h want %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_reset_abort();
    test_wait0();
    test_ignore_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
